// File: rtl/link_return_stack.sv
// Return-address stack for MIPS call/return pairs: pushes PC+8 on committed
// linking instructions, pops on JR/JALR $31 and reports the verified prediction.
module link_return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    input  logic [31:0]        pc,
    input  logic [31:0]        rs_value,
    output logic               predict_valid,
    output logic [31:0]        predict_addr,
    output logic               mispredict,
    output logic [PTR_W:0]     count,
    output logic               empty,
    output logic               full
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_tp;
    logic [CNT_W-1:0] r_count;
    logic             r_predict_valid;
    logic [31:0]      r_predict_addr;
    logic             r_mispredict;

    logic [5:0]       w_opcode;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [5:0]       w_funct;
    logic             w_jal;
    logic             w_regimm_link;
    logic             w_jalr;
    logic             w_jr;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_idx;
    logic [31:0]      w_top;
    logic [31:0]      w_link_addr;

    // Instruction field decode
    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_funct  = instruction[5:0];

    assign w_jal         = (w_opcode == 6'b000011);
    assign w_regimm_link = (w_opcode == 6'b000001) &&
                           ((w_rt == 5'b10000) || (w_rt == 5'b10001));
    assign w_jalr        = (w_opcode == 6'b000000) && (w_funct == 6'b001001);
    assign w_jr          = (w_opcode == 6'b000000) && (w_funct == 6'b001000);

    assign w_push = instr_valid &&
                    (w_jal || w_regimm_link || (w_jalr && (w_rd == 5'd31)));
    assign w_pop  = instr_valid && (w_jr || w_jalr) && (w_rs == 5'd31);

    assign w_empty     = (r_count == CNT_W'(0));
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_top_idx   = r_tp - PTR_W'(1);
    assign w_top       = r_mem[w_top_idx];
    assign w_link_addr = 32'(pc + 32'd8);

    // Stack storage, pointer/count update and registered prediction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 32'd0;
            end
            r_tp            <= '0;
            r_count         <= '0;
            r_predict_valid <= 1'b0;
            r_predict_addr  <= 32'd0;
            r_mispredict    <= 1'b0;
        end else begin
            r_predict_valid <= w_pop;
            if (w_pop) begin
                if (w_empty) begin
                    r_predict_addr <= 32'd0;
                    r_mispredict   <= 1'b1;
                end else begin
                    r_predict_addr <= w_top;
                    r_mispredict   <= (w_top != rs_value);
                end
            end

            if (w_push && !w_pop) begin
                r_mem[r_tp] <= w_link_addr;
                r_tp        <= r_tp + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop && !w_push) begin
                if (!w_empty) begin
                    r_tp    <= w_top_idx;
                    r_count <= r_count - CNT_W'(1);
                end
            end else if (w_pop && w_push) begin
                // Link address replaces the slot just popped; empty stack grows to one
                if (w_empty) begin
                    r_mem[r_tp] <= w_link_addr;
                    r_tp        <= r_tp + PTR_W'(1);
                    r_count     <= CNT_W'(1);
                end else begin
                    r_mem[w_top_idx] <= w_link_addr;
                end
            end
        end
    end

    assign predict_valid = r_predict_valid;
    assign predict_addr  = r_predict_addr;
    assign mispredict    = r_mispredict;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;

endmodule

// File: tb/tb_link_return_stack.sv
// Self-checking bench for link_return_stack: directed call/return scenarios
// plus random instruction streams against a queue-based reference model.
module tb_link_return_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              clk;
    logic              reset;
    logic              instr_valid;
    logic [31:0]       instruction;
    logic [31:0]       pc;
    logic [31:0]       rs_value;
    logic              predict_valid;
    logic [31:0]       predict_addr;
    logic              mispredict;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;

    int checks;
    int failures;

    logic [31:0] model_q [$];
    logic        exp_pv;
    logic [31:0] exp_addr;
    logic        exp_mis;

    link_return_stack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .instruction(instruction), .pc(pc), .rs_value(rs_value),
        .predict_valid(predict_valid), .predict_addr(predict_addr),
        .mispredict(mispredict), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_jal();
        return {6'b000011, 26'h0};
    endfunction
    function automatic logic [31:0] enc_regimm(input logic [4:0] rt);
        return {6'b000001, 5'd3, rt, 16'h0004};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [4:0] rs, input logic [4:0] rd);
        return {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
    endfunction
    function automatic logic [31:0] enc_jr(input logic [4:0] rs);
        return {6'b000000, rs, 15'd0, 6'b001000};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        chk({tag, ".pvalid"}, 32'(predict_valid), 32'(exp_pv));
        chk({tag, ".paddr"}, predict_addr, exp_addr);
        chk({tag, ".mispred"}, 32'(mispredict), 32'(exp_mis));
    endtask

    // Drive one committing slot, advance the reference model, check after the edge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic [31:0] rsv);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        is_push;
        logic        is_pop;
        logic [31:0] t;
        @(negedge clk);
        instr_valid = v;
        instruction = ins;
        pc          = p;
        rs_value    = rsv;
        op = ins[31:26];
        fn = ins[5:0];
        is_push = v && ((op == 6'd3) ||
                        (op == 6'd1 && (ins[20:16] == 5'd16 || ins[20:16] == 5'd17)) ||
                        (op == 6'd0 && fn == 6'd9 && ins[15:11] == 5'd31));
        is_pop  = v && op == 6'd0 && (fn == 6'd8 || fn == 6'd9) && ins[25:21] == 5'd31;
        exp_pv = is_pop;
        if (is_pop) begin
            if (model_q.size() > 0) begin
                t = model_q.pop_back();
                exp_addr = t;
                exp_mis  = (t != rsv);
            end else begin
                exp_addr = 32'd0;
                exp_mis  = 1'b1;
            end
        end
        if (is_push) begin
            model_q.push_back(p + 32'd8);
            if (model_q.size() > DEPTH) void'(model_q.pop_front());
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_pv   = 1'b0;
        exp_addr = 32'd0;
        exp_mis  = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] rsv;
        logic [4:0]  r1;
        logic [4:0]  r2;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'd0;
        pc = 32'd0;
        rs_value = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Mid-run async reset with three entries, plus a pop during reset
        step("rst_p0", 1, enc_jal(), 32'h10, 0);
        step("rst_p1", 1, enc_jal(), 32'h20, 0);
        step("rst_p2", 1, enc_jal(), 32'h30, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_state("rst_async");
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = enc_jr(5'd31);
        @(posedge clk);
        #1;
        check_state("rst_pop");
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0;
        step("rst_under", 1, enc_jr(5'd31), 32'h40, 32'h44);

        // Simple call/return
        step("cr_jal", 1, enc_jal(), 32'h0040_0010, 0);
        step("cr_jr", 1, enc_jr(5'd31), 32'h0040_1000, 32'h0040_0018);

        // Nesting
        step("nest_jal", 1, enc_jal(), 32'h100, 0);
        step("nest_bgezal", 1, enc_regimm(5'b10001), 32'h200, 0);
        step("nest_jalr", 1, enc_jalr(5'd7, 5'd31), 32'h300, 0);
        step("nest_r0", 1, enc_jr(5'd31), 32'h900, 32'h308);
        step("nest_r1", 1, enc_jr(5'd31), 32'h904, 32'h208);
        step("nest_r2", 1, enc_jr(5'd31), 32'h908, 32'h104);

        // Overflow then drain to underflow
        for (int i = 0; i < 10; i++) step("ovf_push", 1, enc_jal(), 32'(i * 16), 0);
        for (int i = 0; i < 9; i++) step("ovf_pop", 1, enc_jr(5'd31), 32'h800, 32'h98 - 32'(i * 16));

        // Non-linking instructions and pc wrap
        step("nl_seed", 1, enc_jal(), 32'h1000, 0);
        step("nl_jalr5", 1, enc_jalr(5'd6, 5'd5), 32'h1100, 0);
        step("nl_jr4", 1, enc_jr(5'd4), 32'h1104, 0);
        step("nl_bltz", 1, enc_regimm(5'b00000), 32'h1108, 0);
        step("nl_bltzal", 1, enc_regimm(5'b10000), 32'h110C, 0);
        step("nl_invalid", 0, enc_jr(5'd31), 32'h1110, 32'h1114);
        step("nl_wrap", 1, enc_jal(), 32'hFFFF_FFFC, 0);
        step("nl_wrap_pop", 1, enc_jr(5'd31), 32'h0, 32'h4);
        step("nl_pop1", 1, enc_jr(5'd31), 32'h0, 32'h1114);
        step("nl_pop2", 1, enc_jr(5'd31), 32'h0, 32'h1008);

        // Simultaneous pop and push
        step("sim_seed", 1, enc_jal(), 32'h4F8, 0);
        step("sim_jalr", 1, enc_jalr(5'd31, 5'd31), 32'h600, 32'h500);
        step("sim_pop", 1, enc_jr(5'd31), 32'h700, 32'h608);
        step("sim_empty", 1, enc_jalr(5'd31, 5'd31), 32'h800, 32'h0);

        // Random instruction streams
        for (int n = 0; n < 3000; n++) begin
            r1 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd31;
            r2 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd31;
            case ($urandom_range(0, 7))
                0, 1: ins = enc_jal();
                2:    ins = enc_regimm(($urandom_range(0, 1) == 0) ? 5'b10000 : 5'b10001);
                3:    ins = enc_regimm(5'($urandom));
                4:    ins = enc_jalr(r1, r2);
                5, 6: ins = enc_jr(r1);
                default: ins = $urandom;
            endcase
            if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
                rsv = model_q[model_q.size() - 1];
            else
                rsv = $urandom;
            step("rand", ($urandom_range(0, 7) != 0), ins, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rsv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
